cv32e40x_wb_event_tracer: RTL and testbench



---
 rtl/cv32e40x_pkg.sv | 27 ++
 rtl/cv32e40x_trace_fifo.sv | 57 +++++
 rtl/cv32e40x_wb_event_tracer.sv | 99 +++++++++
 tb/tb_cv32e40x_wb_event_tracer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the writeback stage: EX/WB pipeline register and trace record layout.
package cv32e40x_pkg;

  localparam int TRACE_TS_WIDTH_MAX = 64;

  typedef struct packed {
    logic        instr_valid;
    logic        illegal_insn;
    logic [31:0] pc;
    logic [31:0] instr;
  } ex_wb_pipe_t;

  typedef enum logic {
    TRACE_ILLEGAL  = 1'b0,
    TRACE_OVERFLOW = 1'b1
  } trace_kind_e;

  // 'time' is a reserved word, so the timestamp field is named time_stamp
  typedef struct packed {
    trace_kind_e                   kind;
    logic [31:0]                   pc;
    logic [3:0]                    hartid;
    logic [TRACE_TS_WIDTH_MAX-1:0] time_stamp;
    logic [15:0]                   drops;
  } trace_rec_t;

endpackage

// File: rtl/cv32e40x_trace_fifo.sv
// Generic synchronous FIFO without fall-through; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cv32e40x_trace_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_mem[gi] <= i_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cv32e40x_wb_event_tracer.sv
// Writeback-stage event tracer: queues retiring illegal instructions and reports
// FIFO losses in-band as OVERFLOW records carrying the drop count.
module cv32e40x_wb_event_tracer
  import cv32e40x_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  ex_wb_pipe_t         ex_wb_pipe_i,
  input  logic                wb_valid_i,
  input  logic [31:0]         mhartid_i,
  input  logic                enable_i,
  output logic                rec_valid_o,
  input  logic                rec_ready_i,
  output trace_kind_e         rec_kind_o,
  output logic [31:0]         rec_pc_o,
  output logic [3:0]          rec_hartid_o,
  output logic [TS_WIDTH-1:0] rec_time_o,
  output logic [15:0]         rec_drops_o
);

  logic [TS_WIDTH-1:0] r_ts;
  logic [15:0]         r_drops;
  logic                r_ovf_pending;

  logic       w_capture;
  logic       w_read;
  logic       w_slot;
  logic       w_push;
  logic       w_drop;
  logic       w_full;
  logic       w_empty;
  trace_rec_t w_rec;
  trace_rec_t w_head;
  logic       w_unused;

  assign w_capture = enable_i && wb_valid_i && ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.illegal_insn;
  assign w_read    = rec_valid_o && rec_ready_i;
  assign w_slot    = !w_full || w_read;
  assign w_push    = w_slot && (r_ovf_pending || w_capture);
  // A capture is lost when there is no slot or the overflow record takes it
  assign w_drop    = w_capture && (!w_slot || r_ovf_pending);

  always_comb begin
    w_rec            = '0;
    w_rec.hartid     = mhartid_i[3:0];
    w_rec.time_stamp = TRACE_TS_WIDTH_MAX'(r_ts);
    if (r_ovf_pending) begin
      w_rec.kind  = TRACE_OVERFLOW;
      w_rec.drops = r_drops;
    end else begin
      w_rec.kind = TRACE_ILLEGAL;
      w_rec.pc   = ex_wb_pipe_i.pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts          <= '0;
      r_drops       <= '0;
      r_ovf_pending <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (r_ovf_pending && w_slot) begin
        r_drops       <= w_drop ? 16'd1 : 16'd0;
        r_ovf_pending <= w_drop;
      end else if (w_drop) begin
        if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
        r_ovf_pending <= 1'b1;
      end
    end
  end

  cv32e40x_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (w_read),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rec_valid_o  = !w_empty;
  assign rec_kind_o   = w_head.kind;
  assign rec_pc_o     = w_head.pc;
  assign rec_hartid_o = w_head.hartid;
  assign rec_time_o   = w_head.time_stamp[TS_WIDTH-1:0];
  assign rec_drops_o  = w_head.drops;

  assign w_unused = ^{mhartid_i[31:4], ex_wb_pipe_i.instr, w_head.time_stamp};

endmodule

// File: tb/tb_cv32e40x_wb_event_tracer.sv
// Randomized and directed stimulus checked by a scoreboard fed from a queue-based reference model.
module tb_cv32e40x_wb_event_tracer;
  import cv32e40x_pkg::*;

  localparam int DEPTH = 4;
  localparam int TSW   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  ex_wb_pipe_t      pipe;
  logic             wb_valid;
  logic [31:0]      mhartid;
  logic             enable;
  logic             rec_valid;
  logic             rec_ready;
  trace_kind_e      rec_kind;
  logic [31:0]      rec_pc;
  logic [3:0]       rec_hartid;
  logic [TSW-1:0]   rec_time;
  logic [15:0]      rec_drops;

  typedef struct {
    bit          ovf;
    logic [31:0] pc;
    logic [3:0]  hart;
    logic [7:0]  tm;
    logic [15:0] drops;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          m_ts = 0;
  int          m_drops = 0;
  bit          m_pend = 0;

  cv32e40x_wb_event_tracer #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_wb_pipe_i (pipe),
    .wb_valid_i   (wb_valid),
    .mhartid_i    (mhartid),
    .enable_i     (enable),
    .rec_valid_o  (rec_valid),
    .rec_ready_i  (rec_ready),
    .rec_kind_o   (rec_kind),
    .rec_pc_o     (rec_pc),
    .rec_hartid_o (rec_hartid),
    .rec_time_o   (rec_time),
    .rec_drops_o  (rec_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model + monitor, evaluated mid-cycle while inputs and outputs are settled
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ts = 0; m_drops = 0; m_pend = 0;
    end else begin
      int   occ;
      bit   rd, slot, cap;
      exp_t e;
      occ = exp_q.size();
      checks++;
      if (rec_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL valid: got %b expected %b (ts=%0d)", rec_valid, occ > 0, m_ts);
      end
      if (rec_valid === 1'b1 && occ > 0) begin
        e = exp_q[0];
        checks++;
        if ((rec_kind == TRACE_OVERFLOW) != e.ovf || rec_pc !== e.pc || rec_hartid !== e.hart ||
            rec_time !== e.tm || rec_drops !== e.drops) begin
          errors++;
          $display("FAIL record: got kind=%0d pc=%h hart=%h time=%0d drops=%0d expected kind=%0d pc=%h hart=%h time=%0d drops=%0d",
                   rec_kind, rec_pc, rec_hartid, rec_time, rec_drops, e.ovf, e.pc, e.hart, e.tm, e.drops);
        end
        if (rec_ready)
          $display("rec kind=%0d pc=%h hart=%0d time=%0d drops=%0d", rec_kind, rec_pc, rec_hartid, rec_time, rec_drops);
      end
      rd   = (occ > 0) && rec_ready;
      if (rd) void'(exp_q.pop_front());
      slot = (occ < DEPTH) || rd;
      cap  = enable && wb_valid && pipe.instr_valid && pipe.illegal_insn;
      if (m_pend && slot) begin
        exp_q.push_back('{ovf: 1'b1, pc: 32'h0, hart: mhartid[3:0], tm: 8'(m_ts), drops: 16'(m_drops)});
        m_drops = cap ? 1 : 0;
        m_pend  = cap;
      end else if (cap && slot) begin
        exp_q.push_back('{ovf: 1'b0, pc: pipe.pc, hart: mhartid[3:0], tm: 8'(m_ts), drops: 16'h0});
      end else if (cap) begin
        if (m_drops < 65535) m_drops++;
        m_pend = 1;
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  task automatic step(input bit ev, input logic [31:0] pc, input bit rdy, input bit en);
    @(posedge clk); #1;
    wb_valid          = ev;
    pipe.instr_valid  = ev;
    pipe.illegal_insn = ev;
    pipe.instr        = $urandom;
    pipe.pc           = pc;
    rec_ready         = rdy;
    enable            = en;
    mhartid           = $urandom;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy, 1'b1);
  endtask

  initial begin
    pipe = '0; wb_valid = 0; mhartid = 0; enable = 1; rec_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(rec_valid), 64'h0);
    check("reset_kind", 64'(rec_kind), 64'(TRACE_ILLEGAL));
    check("reset_pc", 64'(rec_pc), 64'h0);
    check("reset_hart", 64'(rec_hartid), 64'h0);
    check("reset_time", 64'(rec_time), 64'h0);
    check("reset_drops", 64'(rec_drops), 64'h0);
    rst_n = 1;

    // Single event at timestamp 10, visible one cycle later
    idle(9, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("single_valid", 64'(rec_valid), 64'h1);
    check("single_pc", 64'(rec_pc), 64'h100);
    check("single_time", 64'(rec_time), 64'd10);
    idle(3, 1'b1);

    // Backpressure: fill, hold, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1);
    idle(5, 1'b0);
    idle(6, 1'b1);

    // Overflow: 7 events into a 4-deep FIFO
    for (int i = 0; i < 7; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
    idle(10, 1'b1);

    // Collision: overflow insertion wins the freed slot over a new event
    for (int i = 0; i < 5; i++) step(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b1);
    step(1'b1, 32'h2100, 1'b1, 1'b1);
    idle(10, 1'b1);

    // Gating: disabled events neither capture nor count as drops
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3100 + 32'(i * 4), 1'b0, 1'b0);
    idle(10, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h3200, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Drop counter saturation
    for (int i = 0; i < 65545; i++) step(1'b1, 32'h4000, 1'b0, 1'b1);
    idle(10, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      wb_valid          = ($urandom_range(0, 3) != 0);
      pipe.instr_valid  = ($urandom_range(0, 5) != 0);
      pipe.illegal_insn = ($urandom_range(0, 2) != 0);
      pipe.pc           = $urandom & 32'hFFFF_FFFC;
      pipe.instr        = $urandom;
      rec_ready         = ($urandom_range(0, 2) == 0);
      enable            = ($urandom_range(0, 7) != 0);
      mhartid           = $urandom;
    end
    idle(10, 1'b1);

    // Asynchronous reset with records queued
    step(1'b1, 32'h5000, 1'b0, 1'b1);
    step(1'b1, 32'h5004, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("pre_reset_valid", 64'(rec_valid), 64'h1);
    #2;
    rst_n = 0;
    #1;
    check("async_reset_valid", 64'(rec_valid), 64'h0);
    check("async_reset_pc", 64'(rec_pc), 64'h0);
    idle(2, 1'b1);
    rst_n = 1;
    idle(6, 1'b1);
    check("post_reset_valid", 64'(rec_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
